// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit and the ALU it drives.
// Holds opcode/funct constants, ALU control codes, FSM state codes and mux selects.
// Ports: none (package only).
package mc_pkg;

  // Instruction opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // ALU control codes, shared with the ALU
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_BEQ = 4'b1000;
  localparam logic [3:0] ALUC_BNE = 4'b1100;

  // FSM state codes, visible on state_dbg
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR = 4'd3;
  localparam logic [3:0] ST_MEM_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_R_EXEC   = 4'd7;
  localparam logic [3:0] ST_R_WB     = 4'd8;
  localparam logic [3:0] ST_I_EXEC   = 4'd9;
  localparam logic [3:0] ST_I_WB     = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Which decode rule the ALU control uses in the current state
  typedef enum logic [2:0] {
    ACLS_NONE,
    ACLS_ADD,
    ACLS_R,
    ACLS_I,
    ACLS_BR
  } alu_cls_e;

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: picks the ALU code for the current state class.
// Latency: purely combinational. Backpressure: none.
// Ports: cls (state class), opcode, funct in; aluc, funct_ok out.
module alu_dec
  import mc_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluc,
  output logic       funct_ok
);

  always_comb begin
    aluc     = 4'b0000;
    funct_ok = 1'b1;
    case (cls)
      ACLS_ADD: aluc = ALUC_ADD;
      ACLS_R: begin
        case (funct)
          FN_ADD:  aluc = ALUC_ADD;
          FN_SUB:  aluc = ALUC_SUB;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          default: begin
            // Unknown funct still drives ADD so the ALU sees a defined op.
            aluc     = ALUC_ADD;
            funct_ok = 1'b0;
          end
        endcase
      end
      ACLS_I: begin
        case (opcode)
          OP_ANDI: aluc = ALUC_AND;
          OP_ORI:  aluc = ALUC_OR;
          default: aluc = ALUC_ADD;
        endcase
      end
      ACLS_BR: aluc = (opcode == OP_BNE) ? ALUC_BNE : ALUC_BEQ;
      default: aluc = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-5 cycles per instruction at zero wait; outputs Moore except FETCH ir/pc write and BRANCH pc_write.
// Backpressure: stalls in FETCH, MEM_RD, MEM_WR until mem_ready; no timeout.
// Ports: clk, rst_n; opcode/funct/zero/mem_ready in; ALU code, mux selects, enables,
//        illegal pulse and state_dbg out.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] aluc,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  logic [3:0] state_q, state_d;
  alu_cls_e   alu_cls;
  logic       funct_ok;

  alu_dec u_alu_dec (
    .cls      (alu_cls),
    .opcode   (opcode),
    .funct    (funct),
    .aluc     (aluc),
    .funct_ok (funct_ok)
  );

  always_comb begin
    state_d    = state_q;
    alu_cls    = ACLS_NONE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = PCSRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_cls   = ACLS_ADD;
        alu_src_b = SRCB_FOUR;
        // IR load and PC+4 commit only in the cycle memory delivers.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_cls   = ACLS_ADD;
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:                 state_d = ST_R_EXEC;
          OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = ST_BRANCH;
          OP_J:                     state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_I_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_cls   = ACLS_ADD;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_cls   = ACLS_R;
        alu_src_a = 1'b1;
        if (funct_ok) begin
          state_d = ST_R_WB;
        end else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_cls   = ACLS_I;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_cls   = ACLS_BR;
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        // Taken decision comes straight from the ALU compare this cycle.
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign state_dbg = state_q;

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit that drives the datapath ALU (4-bit ALU control code, `Zero` flag) and the shared instruction/data memory. It sequences each MIPS-subset instruction through fetch, decode, execute, memory and writeback states. It stalls on a memory-ready handshake and asserts ALU codes and datapath enables cycle by cycle. It sits beside the datapath: it consumes `opcode`, `funct` and the ALU `Zero` output, and produces every mux select and write enable.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26], valid from the DECODE state onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU Zero flag, combinational in the same cycle
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `aluc`  out  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 BEQ-compare, 1100 BNE-compare
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `pc_source`  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  enables
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-data select: 0 = ALUOut, 1 = MDR
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct
- `state_dbg`  out  4  current state encoding

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- IDLE is entered only from reset. Every output is 0 in IDLE. IDLE→FETCH unconditionally.
- FETCH:
  - Asserts mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, aluc=ADD, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: aluc=ADD, alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000100 (beq), 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi), 001100 (andi), 001101 (ori) → I_EXEC
  - any other opcode → FETCH, with a pulse on illegal
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluc=ADD. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write, i_or_d=1. Holds until mem_ready=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. aluc is decoded from funct:
  - 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR
  - any other funct → aluc=ADD, pulse illegal, go to FETCH (no writeback)
  - legal funct → R_WB
- R_WB: reg_write, reg_dst=1, mem_to_reg=0. Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. aluc is ADD for addi, AND for andi, OR for ori. Then I_WB.
- I_WB: reg_write, reg_dst=0, mem_to_reg=0. Then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, pc_source=01.
  - aluc=1000 for beq, 1100 for bne.
  - pc_write = zero for beq; pc_write = ~zero for bne.
  - Then FETCH.
- JUMP: pc_write, pc_source=10. Then FETCH.
- Any output not listed for a state is 0 in that state.

## Timing
- State register resets asynchronously to IDLE; every output is 0 while rst_n=0.
- Outputs are Moore (decoded from state), with two exceptions:
  - BRANCH pc_write depends combinationally on zero.
  - FETCH ir_write/pc_write depend combinationally on mem_ready.
- Cycles per instruction with zero-wait memory (mem_ready held at 1): lw 5, sw 4, R-type 4, I-type ALU 4, beq/bne 3, j 3, illegal 2.
- Each wait cycle adds one cycle in FETCH, MEM_RD or MEM_WR. There is no timeout.
- rst_n asserted mid-instruction: go to IDLE immediately and drop all enables in the same cycle. No partial writeback completes.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.

## Structure
- Shared package `mc_pkg`: opcode and funct constants, the ALUC code constants (shared with the ALU), the state enum, and the alu_src_b/pc_source encodings.
- One sub-module, `alu_dec`: maps (state class, opcode, funct) to aluc plus a funct-legal flag. It is purely combinational.

## Test plan
- Reset: assert rst_n=0 in MEM_RD → all enables 0 immediately, state_dbg=IDLE. Release → FETCH on the next edge.
- Zero-wait sequence lw, sw, add (funct 100000) → 5/4/4 cycles. aluc=0010 in R_EXEC, reg_write in the MEM_WB and R_WB states.
- beq with zero=1 → pc_write=1, aluc=1000. bne with zero=1 → pc_write=0, aluc=1100.
- FETCH with mem_ready low for 3 cycles → ir_write/pc_write stay 0 for those 3 cycles, then pulse for exactly 1 cycle.
- R-type funct 101010 → aluc=0010, illegal pulses once, no reg_write, FETCH follows. Same for opcode 111111 from DECODE.
- ori → aluc=0001, alu_src_b=10 in I_EXEC. I_WB has reg_dst=0, mem_to_reg=0.
